hazard_ctrl_pipe: RTL and testbench
===================================

HAZARD_CTRL_PIPE -- requirements
Module: hazard_ctrl_pipe

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: clk and reset.
REQ-002 The ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decode-stage controls
- ResultSrcD  in  2  decode result select: 00 ALU, 01 memory, 10 PC+4
- ALUControlD  in  3  decode ALU operation
- Rs1D, Rs2D, RdD  in  5 each  decode register addresses
- ZeroE  in  1  ALU zero flag of the instruction in execute
- RegWriteE, MemWriteE, ALUSrcE  out  1 each  execute controls
- ResultSrcE  out  2  execute result select
- ALUControlE  out  3  execute ALU operation
- RegWriteM, MemWriteM  out  1 each  memory-stage controls
- ResultSrcM  out  2  memory-stage result select
- RegWriteW  out  1  writeback register write enable
- ResultSrcW  out  2  writeback result select
- RdE, RdM, RdW  out  5 each  destination register per stage
- PCSrcE  out  1  take branch or jump target
- ForwardAE, ForwardBE  out  2 each  operand select: 00 regfile, 01 writeback, 10 memory
- StallF, StallD  out  1 each  hold the PC and the fetch/decode register
- FlushD  out  1  clear the fetch/decode register
- FlushE  out  1  bubble inserted into execute (internal flush, exported for observation)

Function
REQ-003 The D->E register SHALL hold: all D controls, Rs1, Rs2 and Rd.
REQ-004 The D->E register SHALL load every rising edge; when FlushE=1 it SHALL load all zeros instead.
REQ-005 The E->M register SHALL load every edge with RegWrite, MemWrite, ResultSrc and Rd; it SHALL have no stall or flush.
REQ-006 The M->W register SHALL load every edge with RegWrite, ResultSrc and Rd; it SHALL have no stall or flush.
REQ-007 A decode-stage control SHALL appear on its E output 1 cycle after capture, on its M output after 2 cycles and on its W output after 3 cycles.
REQ-008 PCSrcE SHALL be combinational: (BranchE AND ZeroE) OR JumpE.
REQ-009 ForwardAE SHALL be computed combinationally, in priority order:
- 10 if RegWriteM=1, RdM=Rs1E and Rs1E!=0;
- else 01 if RegWriteW=1, RdW=Rs1E and Rs1E!=0;
- else 00.
REQ-010 ForwardBE SHALL follow the same rule as REQ-009 using Rs2E.
REQ-011 The load-use stall condition lwStall SHALL be: ResultSrcE=01, RdE!=0, and (Rs1D=RdE or Rs2D=RdE).
REQ-012 StallF and StallD SHALL both equal lwStall AND NOT PCSrcE.
REQ-013 FlushD SHALL equal PCSrcE.
REQ-014 FlushE SHALL equal lwStall OR PCSrcE.
REQ-015 When lwStall and PCSrcE are both 1, the flush SHALL win: no stall, FlushD=1, FlushE=1.
REQ-016 A load stall SHALL last exactly 1 cycle, because the bubble clears ResultSrcE on the next edge.
REQ-017 Register x0 SHALL never cause forwarding or a stall.
REQ-018 JumpE and BranchE SHALL be internal only; PCSrcE SHALL be their only effect.

Reset
REQ-019 When reset=1, all pipeline registers SHALL clear to 0 immediately and asynchronously, independent of clk.
REQ-020 While reset=1, every registered output SHALL read 0, so PCSrcE=0, ForwardAE=ForwardBE=00, and all stalls and flushes are 0.
REQ-021 Reset asserted mid-operation SHALL discard every in-flight instruction.
REQ-022 Capture SHALL resume on the first rising edge after reset deasserts.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- add x5 in D, RegWriteD=1, RdD=5 -> RegWriteE=1 and RdE=5 after 1 edge, RegWriteM=1 after 2 edges, RegWriteW=1 and RdW=5 after 3 edges.
- RdM=5 with RegWriteM=1, RdW=5 with RegWriteW=1, Rs1E=5 -> ForwardAE=10; with RegWriteM=0 -> ForwardAE=01; with Rs1E=0 -> ForwardAE=00.
- Load to x6 in E (ResultSrcE=01, RdE=6), Rs2D=6 -> StallF=StallD=FlushE=1 for exactly 1 cycle; next cycle ResultSrcE=00 and RegWriteE=0; the following cycle the dependent instruction has ForwardBE=01.
- BranchE=1, ZeroE=1 -> PCSrcE=FlushD=FlushE=1; next cycle all E controls are 0. Same with ZeroE=0 -> PCSrcE=0 and no flush.
- Force lwStall and JumpE=1 together -> StallF=StallD=0, FlushD=FlushE=1.
- Assert reset between clock edges with RegWriteM=1 -> RegWriteM=0 before the next edge; after deassert, the pipeline refills with 3-cycle latency.

Source files
------------

// File: rtl/hazard_ctrl_pipe.sv
// hazard_ctrl_pipe: control path of a 5-stage in-order pipeline. Carries decode
// controls through execute, memory and writeback, resolves branches/jumps in
// execute, selects operand forwarding and detects load-use hazards.
module hazard_ctrl_pipe (
  input  logic       clk,
  input  logic       reset,
  // Decode-stage controls
  input  logic       RegWriteD,
  input  logic       MemWriteD,
  input  logic       JumpD,
  input  logic       BranchD,
  input  logic       ALUSrcD,
  input  logic [1:0] ResultSrcD,
  input  logic [2:0] ALUControlD,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] RdD,
  // ALU zero flag of the instruction in execute
  input  logic       ZeroE,
  // Execute-stage controls
  output logic       RegWriteE,
  output logic       MemWriteE,
  output logic       ALUSrcE,
  output logic [1:0] ResultSrcE,
  output logic [2:0] ALUControlE,
  // Memory-stage controls
  output logic       RegWriteM,
  output logic       MemWriteM,
  output logic [1:0] ResultSrcM,
  // Writeback-stage controls
  output logic       RegWriteW,
  output logic [1:0] ResultSrcW,
  // Destination register per stage
  output logic [4:0] RdE,
  output logic [4:0] RdM,
  output logic [4:0] RdW,
  // Hazard unit
  output logic       PCSrcE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE
);

  localparam logic [1:0] ResultMem = 2'b01;
  localparam logic [1:0] FwdNone   = 2'b00;
  localparam logic [1:0] FwdWb     = 2'b01;
  localparam logic [1:0] FwdMem    = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [1:0] result_src;
    logic [2:0] alu_control;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } de_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [4:0] rd;
  } em_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic [4:0] rd;
  } mw_t;

  de_t  de_d, de_q;
  em_t  em_d, em_q;
  mw_t  mw_d, mw_q;
  logic lw_stall;

  // D->E next state: the decoded instruction, or an all-zero bubble on flush.
  always_comb begin
    de_d = '0;
    if (!FlushE) begin
      de_d.reg_write   = RegWriteD;
      de_d.mem_write   = MemWriteD;
      de_d.jump        = JumpD;
      de_d.branch      = BranchD;
      de_d.alu_src     = ALUSrcD;
      de_d.result_src  = ResultSrcD;
      de_d.alu_control = ALUControlD;
      de_d.rs1         = Rs1D;
      de_d.rs2         = Rs2D;
      de_d.rd          = RdD;
    end
  end

  // E->M and M->W next state: later stages always advance, never stall or flush.
  always_comb begin
    em_d            = '0;
    em_d.reg_write  = de_q.reg_write;
    em_d.mem_write  = de_q.mem_write;
    em_d.result_src = de_q.result_src;
    em_d.rd         = de_q.rd;
    mw_d            = '0;
    mw_d.reg_write  = em_q.reg_write;
    mw_d.result_src = em_q.result_src;
    mw_d.rd         = em_q.rd;
  end

  // Pipeline registers; reset discards every in-flight instruction immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_q <= '0;
      em_q <= '0;
      mw_q <= '0;
    end else begin
      de_q <= de_d;
      em_q <= em_d;
      mw_q <= mw_d;
    end
  end

  // Per-stage control outputs straight from the pipeline registers.
  always_comb begin
    RegWriteE   = de_q.reg_write;
    MemWriteE   = de_q.mem_write;
    ALUSrcE     = de_q.alu_src;
    ResultSrcE  = de_q.result_src;
    ALUControlE = de_q.alu_control;
    RdE         = de_q.rd;
    RegWriteM   = em_q.reg_write;
    MemWriteM   = em_q.mem_write;
    ResultSrcM  = em_q.result_src;
    RdM         = em_q.rd;
    RegWriteW   = mw_q.reg_write;
    ResultSrcW  = mw_q.result_src;
    RdW         = mw_q.rd;
  end

  // Branch resolution and load-use detection; a taken branch/jump overrides the
  // stall because the dependent instruction in decode is being squashed anyway.
  always_comb begin
    PCSrcE   = (de_q.branch & ZeroE) | de_q.jump;
    lw_stall = (de_q.result_src == ResultMem) && (de_q.rd != 5'd0) &&
               ((Rs1D == de_q.rd) || (Rs2D == de_q.rd));
    StallF   = lw_stall & ~PCSrcE;
    StallD   = lw_stall & ~PCSrcE;
    FlushD   = PCSrcE;
    FlushE   = lw_stall | PCSrcE;
  end

  // Operand forwarding; the memory stage holds the younger result so it wins.
  always_comb begin
    ForwardAE = FwdNone;
    if (em_q.reg_write && (em_q.rd == de_q.rs1) && (de_q.rs1 != 5'd0)) begin
      ForwardAE = FwdMem;
    end else if (mw_q.reg_write && (mw_q.rd == de_q.rs1) && (de_q.rs1 != 5'd0)) begin
      ForwardAE = FwdWb;
    end
    ForwardBE = FwdNone;
    if (em_q.reg_write && (em_q.rd == de_q.rs2) && (de_q.rs2 != 5'd0)) begin
      ForwardBE = FwdMem;
    end else if (mw_q.reg_write && (mw_q.rd == de_q.rs2) && (de_q.rs2 != 5'd0)) begin
      ForwardBE = FwdWb;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// tb_hazard_ctrl_pipe: table-driven, directed and random checks of the pipeline
// control/hazard block against an instruction-history reference model.
module tb_hazard_ctrl_pipe;

  logic       clk, reset;
  logic       RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       ZeroE;
  logic       RegWriteE, MemWriteE, ALUSrcE;
  logic [1:0] ResultSrcE;
  logic [2:0] ALUControlE;
  logic       RegWriteM, MemWriteM;
  logic [1:0] ResultSrcM;
  logic       RegWriteW;
  logic [1:0] ResultSrcW;
  logic [4:0] RdE, RdM, RdW;
  logic       PCSrcE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, FlushD, FlushE;

  hazard_ctrl_pipe dut (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .PCSrcE(PCSrcE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw, mw, jmp, br, als;
    logic [1:0] rsrc;
    logic [2:0] aluc;
    logic [4:0] rs1, rs2, rd;
  } instr_t;

  typedef struct packed {
    logic       rw_e;
    logic [4:0] rd_e;
    logic       rw_m;
    logic [4:0] rd_m;
    logic       rw_w;
    logic [4:0] rd_w;
    logic [1:0] fa, fb;
    logic       stall, fd, fe, pc;
  } exp_t;

  typedef struct packed {
    instr_t d;
    logic   z;
    exp_t   e;
  } vec_t;

  int     n_vec  = 0;
  int     n_fail = 0;
  instr_t hist[$];  // hist[0] in execute, hist[1] in memory, hist[2] in writeback
  vec_t   tbl[9];
  instr_t nop = '0;

  function automatic instr_t mk(int rw, int mw, int jmp, int br, int als, int rsrc, int aluc,
                                int rs1, int rs2, int rd);
    instr_t r;
    r.rw = 1'(rw); r.mw = 1'(mw); r.jmp = 1'(jmp); r.br = 1'(br); r.als = 1'(als);
    r.rsrc = 2'(rsrc); r.aluc = 3'(aluc);
    r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
    return r;
  endfunction

  function automatic exp_t ex(int rw_e, int rd_e, int rw_m, int rd_m, int rw_w, int rd_w,
                              int fa, int fb, int stall, int fd, int fe, int pc);
    exp_t r;
    r.rw_e = 1'(rw_e); r.rd_e = 5'(rd_e); r.rw_m = 1'(rw_m); r.rd_m = 5'(rd_m);
    r.rw_w = 1'(rw_w); r.rd_w = 5'(rd_w); r.fa = 2'(fa); r.fb = 2'(fb);
    r.stall = 1'(stall); r.fd = 1'(fd); r.fe = 1'(fe); r.pc = 1'(pc);
    return r;
  endfunction

  function automatic logic [38:0] dut_vec();
    return {RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE,
            RegWriteM, MemWriteM, ResultSrcM, RegWriteW, ResultSrcW,
            RdE, RdM, RdW, PCSrcE, ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE};
  endfunction

  function automatic exp_t dut_sub();
    return {RegWriteE, RdE, RegWriteM, RdM, RegWriteW, RdW, ForwardAE, ForwardBE,
            StallF, FlushD, FlushE, PCSrcE};
  endfunction

  // Forward from the youngest older writer of a non-zero source register.
  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (hist[1].rw && hist[1].rd == rs) return 2'b10;
    if (hist[2].rw && hist[2].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_pc(input logic z);
    return (hist[0].br & z) | hist[0].jmp;
  endfunction

  function automatic logic m_lw(input instr_t d);
    return (hist[0].rsrc == 2'b01) && (hist[0].rd != 5'd0) &&
           ((d.rs1 == hist[0].rd) || (d.rs2 == hist[0].rd));
  endfunction

  function automatic logic [38:0] model_vec(input instr_t d, input logic z);
    instr_t e = hist[0];
    instr_t m = hist[1];
    instr_t w = hist[2];
    logic   pc = m_pc(z);
    logic   lw = m_lw(d);
    return {e.rw, e.mw, e.als, e.rsrc, e.aluc, m.rw, m.mw, m.rsrc, w.rw, w.rsrc,
            e.rd, m.rd, w.rd, pc, m_fwd(e.rs1), m_fwd(e.rs2),
            lw & ~pc, lw & ~pc, pc, lw | pc};
  endfunction

  task automatic model_reset();
    hist = {};
    repeat (3) hist.push_back('0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input instr_t d, input logic z);
    RegWriteD = d.rw; MemWriteD = d.mw; JumpD = d.jmp; BranchD = d.br; ALUSrcD = d.als;
    ResultSrcD = d.rsrc; ALUControlD = d.aluc;
    Rs1D = d.rs1; Rs2D = d.rs2; RdD = d.rd; ZeroE = z;
  endtask

  // Present an instruction to decode and compare every output with the model.
  task automatic apply(input instr_t d, input logic z);
    drive(d, z);
    #1;
    chk("model", 64'(dut_vec()), 64'(model_vec(d, z)));
  endtask

  // Advance the model history and the DUT by one clock edge.
  task automatic tick(input instr_t d, input logic z);
    logic flush;
    flush = m_lw(d) | m_pc(z);
    hist.push_front(flush ? instr_t'('0) : d);
    void'(hist.pop_back());
    @(posedge clk);
    #1;
  endtask

  task automatic step(input instr_t d, input logic z);
    apply(d, z);
    tick(d, z);
  endtask

  task automatic fwd_seq(input int bw, input int crs1, input logic [1:0] exp_fa);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5), 1'b0);
    step(mk(bw, 0, 0, 0, 0, 0, 0, 0, 0, 5), 1'b0);
    step(mk(1, 0, 0, 0, 0, 0, 0, crs1, 0, 11), 1'b0);
    apply(nop, 1'b0);
    chk("fwd_a", 64'(ForwardAE), 64'(exp_fa));
    tick(nop, 1'b0);
  endtask

  initial begin
    instr_t dep;
    instr_t r;
    logic   rz;

    //          d: rw mw j  b  as rs al rs1 rs2 rd      e: rwE rdE rwM rdM rwW rdW fa fb st fd fe pc
    tbl[0] = {mk(1, 0, 0, 0, 0, 0, 0, 1, 2, 5), 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1] = {mk(1, 0, 0, 0, 0, 0, 1, 5, 0, 6), 1'b0, ex(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2] = {mk(1, 0, 0, 0, 0, 0, 3, 0, 5, 7), 1'b0, ex(1, 6, 1, 5, 0, 0, 2, 0, 0, 0, 0, 0)};
    tbl[3] = {mk(1, 0, 0, 0, 1, 1, 0, 6, 0, 8), 1'b0, ex(1, 7, 1, 6, 1, 5, 0, 1, 0, 0, 0, 0)};
    tbl[4] = {mk(1, 0, 0, 0, 0, 0, 0, 8, 0, 9), 1'b0, ex(1, 8, 1, 7, 1, 6, 1, 0, 1, 0, 1, 0)};
    tbl[5] = {mk(1, 0, 0, 0, 0, 0, 0, 8, 0, 9), 1'b0, ex(0, 0, 1, 8, 1, 7, 0, 0, 0, 0, 0, 0)};
    tbl[6] = {mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0), 1'b1, ex(1, 9, 0, 0, 1, 8, 1, 0, 0, 0, 0, 0)};
    tbl[7] = {mk(1, 0, 0, 0, 0, 0, 0, 9, 0, 10), 1'b1, ex(0, 0, 1, 9, 0, 0, 0, 0, 0, 1, 1, 1)};
    tbl[8] = {mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, ex(0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0)};

    // Reset with busy decode inputs: everything reads zero, across a clock edge too.
    reset = 1'b1;
    drive(mk(1, 1, 1, 1, 1, 1, 7, 3, 3, 3), 1'b1);
    model_reset();
    #2;
    chk("reset_init", 64'(dut_vec()), 64'h0);
    @(posedge clk);
    #1;
    chk("reset_edge", 64'(dut_vec()), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].d, tbl[i].z);
      chk($sformatf("row%0d", i), 64'(dut_sub()), 64'(tbl[i].e));
      tick(tbl[i].d, tbl[i].z);
    end

    // Load to x6 followed by a dependent use of x6 in rs2.
    dep = mk(1, 0, 0, 0, 0, 0, 0, 0, 6, 10);
    step(mk(1, 0, 0, 0, 1, 1, 0, 1, 0, 6), 1'b0);
    apply(dep, 1'b0);
    chk("lw_stall", 64'({StallF, StallD, FlushE}), 64'h7);
    tick(dep, 1'b0);
    apply(dep, 1'b0);
    chk("lw_released", 64'({StallF, StallD, FlushE}), 64'h0);
    chk("lw_bubble", 64'({ResultSrcE, RegWriteE}), 64'h0);
    tick(dep, 1'b0);
    apply(nop, 1'b0);
    chk("lw_fwd_b", 64'(ForwardBE), 64'h1);
    tick(nop, 1'b0);

    // Forwarding priority: memory beats writeback, x0 never forwards.
    fwd_seq(1, 5, 2'b10);
    fwd_seq(0, 5, 2'b01);
    fwd_seq(1, 0, 2'b00);

    // Load-use and jump in the same cycle: flush wins.
    step(mk(1, 0, 1, 0, 0, 1, 0, 0, 0, 6), 1'b0);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 6, 0, 0), 1'b0);
    chk("lw_jump", 64'({StallF, StallD, FlushD, FlushE, PCSrcE}), 64'h7);
    tick(mk(0, 0, 0, 0, 0, 0, 0, 6, 0, 0), 1'b0);

    // Branch not taken, then taken with a squashed follower.
    step(mk(0, 0, 0, 1, 0, 0, 1, 1, 2, 0), 1'b0);
    apply(nop, 1'b0);
    chk("br_not_taken", 64'({PCSrcE, FlushD, FlushE}), 64'h0);
    tick(nop, 1'b0);
    step(mk(0, 0, 0, 1, 0, 0, 1, 1, 2, 0), 1'b0);
    apply(mk(1, 1, 0, 0, 1, 2, 5, 1, 2, 3), 1'b1);
    chk("br_taken", 64'({PCSrcE, FlushD, FlushE}), 64'h7);
    tick(mk(1, 1, 0, 0, 1, 2, 5, 1, 2, 3), 1'b1);
    apply(nop, 1'b0);
    chk("br_squash", 64'({RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE, RdE}), 64'h0);
    tick(nop, 1'b0);

    // Asynchronous reset between edges, then refill latency.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5), 1'b0);
    step(nop, 1'b0);
    chk("pre_reset_m", 64'(RegWriteM), 64'h1);
    drive(mk(1, 1, 0, 0, 1, 1, 5, 3, 3, 3), 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("reset_async_m", 64'(RegWriteM), 64'h0);
    chk("reset_async_all", 64'(dut_vec()), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_held", 64'(dut_vec()), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5), 1'b0);
    apply(nop, 1'b0);
    chk("refill_e", 64'({RegWriteE, RdE}), 64'h25);
    tick(nop, 1'b0);
    apply(nop, 1'b0);
    chk("refill_m", 64'(RegWriteM), 64'h1);
    tick(nop, 1'b0);
    apply(nop, 1'b0);
    chk("refill_w", 64'({RegWriteW, RdW}), 64'h25);
    tick(nop, 1'b0);

    // Random traffic over a small register set to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(49, 0) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        chk("rand_reset", 64'(dut_vec()), 64'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
      end
      r = mk(int'($urandom_range(1, 0)), int'($urandom_range(1, 0)),
             int'($urandom_range(7, 0) == 0), int'($urandom_range(3, 0) == 0),
             int'($urandom_range(1, 0)), int'($urandom_range(3, 0)),
             int'($urandom_range(7, 0)), int'($urandom_range(3, 0)),
             int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
      rz = 1'($urandom_range(1, 0));
      step(r, rz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
